// File: rtl/trig_pkg.sv
// Shared trigonometry definitions: fixed-point format, angle constants and
// the sequencing states used by the sine evaluator.
package trig_pkg;

    localparam int unsigned FRAC_BITS = 16;
    localparam int unsigned FIXED_ONE = 65536;
    localparam int unsigned DEG_360   = 360;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        LOOKUP = 2'd2,
        OUTPUT = 2'd3
    } sine_state_t;

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table: t_out = round(65536 * sin(k_in degrees)) for
// k_in in 0..90; indices past the quarter wave read as zero.
module sine_quarter_rom
    import trig_pkg::*;
(
    input  logic [6:0]  k_in,
    output logic [16:0] t_out
);

    always_comb begin
        t_out = 17'd0;
        case (k_in)
            7'd0:  t_out = 17'd0;      7'd1:  t_out = 17'd1144;   7'd2:  t_out = 17'd2287;
            7'd3:  t_out = 17'd3430;   7'd4:  t_out = 17'd4572;   7'd5:  t_out = 17'd5712;
            7'd6:  t_out = 17'd6850;   7'd7:  t_out = 17'd7987;   7'd8:  t_out = 17'd9121;
            7'd9:  t_out = 17'd10252;  7'd10: t_out = 17'd11380;  7'd11: t_out = 17'd12505;
            7'd12: t_out = 17'd13626;  7'd13: t_out = 17'd14742;  7'd14: t_out = 17'd15855;
            7'd15: t_out = 17'd16962;  7'd16: t_out = 17'd18064;  7'd17: t_out = 17'd19161;
            7'd18: t_out = 17'd20252;  7'd19: t_out = 17'd21336;  7'd20: t_out = 17'd22415;
            7'd21: t_out = 17'd23486;  7'd22: t_out = 17'd24550;  7'd23: t_out = 17'd25607;
            7'd24: t_out = 17'd26656;  7'd25: t_out = 17'd27697;  7'd26: t_out = 17'd28729;
            7'd27: t_out = 17'd29753;  7'd28: t_out = 17'd30767;  7'd29: t_out = 17'd31772;
            7'd30: t_out = 17'd32768;  7'd31: t_out = 17'd33754;  7'd32: t_out = 17'd34729;
            7'd33: t_out = 17'd35693;  7'd34: t_out = 17'd36647;  7'd35: t_out = 17'd37590;
            7'd36: t_out = 17'd38521;  7'd37: t_out = 17'd39441;  7'd38: t_out = 17'd40348;
            7'd39: t_out = 17'd41243;  7'd40: t_out = 17'd42126;  7'd41: t_out = 17'd42995;
            7'd42: t_out = 17'd43852;  7'd43: t_out = 17'd44695;  7'd44: t_out = 17'd45525;
            7'd45: t_out = 17'd46341;  7'd46: t_out = 17'd47143;  7'd47: t_out = 17'd47930;
            7'd48: t_out = 17'd48703;  7'd49: t_out = 17'd49461;  7'd50: t_out = 17'd50203;
            7'd51: t_out = 17'd50931;  7'd52: t_out = 17'd51643;  7'd53: t_out = 17'd52339;
            7'd54: t_out = 17'd53020;  7'd55: t_out = 17'd53684;  7'd56: t_out = 17'd54332;
            7'd57: t_out = 17'd54963;  7'd58: t_out = 17'd55578;  7'd59: t_out = 17'd56175;
            7'd60: t_out = 17'd56756;  7'd61: t_out = 17'd57319;  7'd62: t_out = 17'd57865;
            7'd63: t_out = 17'd58393;  7'd64: t_out = 17'd58903;  7'd65: t_out = 17'd59396;
            7'd66: t_out = 17'd59870;  7'd67: t_out = 17'd60326;  7'd68: t_out = 17'd60764;
            7'd69: t_out = 17'd61183;  7'd70: t_out = 17'd61584;  7'd71: t_out = 17'd61966;
            7'd72: t_out = 17'd62328;  7'd73: t_out = 17'd62672;  7'd74: t_out = 17'd62997;
            7'd75: t_out = 17'd63303;  7'd76: t_out = 17'd63589;  7'd77: t_out = 17'd63856;
            7'd78: t_out = 17'd64104;  7'd79: t_out = 17'd64332;  7'd80: t_out = 17'd64540;
            7'd81: t_out = 17'd64729;  7'd82: t_out = 17'd64898;  7'd83: t_out = 17'd65048;
            7'd84: t_out = 17'd65177;  7'd85: t_out = 17'd65287;  7'd86: t_out = 17'd65376;
            7'd87: t_out = 17'd65446;  7'd88: t_out = 17'd65496;  7'd89: t_out = 17'd65526;
            7'd90: t_out = 17'(FIXED_ONE);
            default: t_out = 17'd0;
        endcase
    end

endmodule

// File: rtl/sine.sv
// Sequential sine evaluator: 9-bit degree angle in, Q16.16 amplitude out,
// via quadrant folding onto a quarter-wave table over four states.
module sine
    import trig_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start,
    input  logic [8:0]         value,
    output logic               done,
    output logic signed [31:0] amp_out
);

    localparam logic [9:0] ANGLE_360 = 10'(DEG_360);

    sine_state_t        state_q, state_d;
    logic [8:0]         angle_q, angle_d;
    logic [6:0]         k_q, k_d;
    logic               neg_q, neg_d;
    logic [16:0]        tbl_q, tbl_d;
    logic               done_q, done_d;
    logic signed [31:0] amp_q, amp_d;

    logic [9:0]         a_pos;
    logic [6:0]         k_fold;
    logic               neg_fold;
    logic [16:0]        rom_t;
    logic signed [31:0] mag;

    sine_quarter_rom u_rom (
        .k_in  (k_q),
        .t_out (rom_t)
    );

    // Codes 360..511 stand for value-512; adding 360 back nets out to -152.
    always_comb begin
        a_pos    = {1'b0, angle_q};
        k_fold   = 7'd0;
        neg_fold = 1'b0;
        if (a_pos >= ANGLE_360) begin
            a_pos = a_pos - 10'd152;
        end
        if (a_pos <= 10'd90) begin
            k_fold = 7'(a_pos);
        end else if (a_pos <= 10'd180) begin
            k_fold = 7'(10'd180 - a_pos);
        end else if (a_pos <= 10'd270) begin
            k_fold   = 7'(a_pos - 10'd180);
            neg_fold = 1'b1;
        end else begin
            k_fold   = 7'(ANGLE_360 - a_pos);
            neg_fold = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        k_d     = k_q;
        neg_d   = neg_q;
        tbl_d   = tbl_q;
        done_d  = 1'b0;
        amp_d   = amp_q;
        mag     = {15'd0, tbl_q};
        case (state_q)
            IDLE: begin
                if (start) begin
                    angle_d = value;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                k_d     = k_fold;
                neg_d   = neg_fold;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                tbl_d   = rom_t;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                // A zero magnitude stays +0 regardless of quadrant.
                amp_d   = (neg_q && (tbl_q != 17'd0)) ? -mag : mag;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            angle_q <= 9'd0;
            k_q     <= 7'd0;
            neg_q   <= 1'b0;
            tbl_q   <= 17'd0;
            done_q  <= 1'b0;
            amp_q   <= 32'sd0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            k_q     <= k_d;
            neg_q   <= neg_d;
            tbl_q   <= tbl_d;
            done_q  <= done_d;
            amp_q   <= amp_d;
        end
    end

    assign done    = done_q;
    assign amp_out = amp_q;

endmodule

// File: tb/tb_sine.sv
// Self-checking bench for the sine evaluator: directed angles plus random
// angles compared against a real-arithmetic sine model.
module tb_sine;

    logic               clk_in;
    logic               rst_in;
    logic               start;
    logic [8:0]         value;
    logic               done;
    logic signed [31:0] amp_out;

    int tests_run = 0;
    int fails     = 0;

    sine dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start   (start),
        .value   (value),
        .done    (done),
        .amp_out (amp_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference: interpret the 9-bit code as degrees and round 65536*sin.
    function automatic int ref_sin(input logic [8:0] v);
        int  a;
        real r;
        a = int'(v);
        if (a >= 360) a = a - 512;
        r = 65536.0 * $sin(real'(a) * 3.14159265358979323846 / 180.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // Issue one conversion from a negedge; returns amp at done and the
    // number of cycles from the accepting edge to done (-1 on timeout).
    task automatic run_conv(input logic [8:0] v, output logic signed [31:0] amp, output int lat);
        value = v;
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        value = 9'($urandom);
        lat   = -1;
        amp   = 32'sd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_in);
            if (done === 1'b1) begin
                lat = c;
                amp = amp_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        @(negedge clk_in);
        rst_in = 1'b1;
        start  = 1'b1;
        value  = 9'd90;
        repeat (2) @(negedge clk_in);
        tests_run++;
        if (done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_done got=%b want=0", done);
        end
        tests_run++;
        if (amp_out !== 32'sd0) begin
            fails++;
            $display("[TB] FAIL reset_amp got=%0d want=0", amp_out);
        end
        rst_in = 1'b0;
        start  = 1'b0;
        seen   = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (done !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("[TB] FAIL idle_no_done got=%0d pulses want=0", seen);
        end
    endtask

    task automatic test_directed();
        logic [8:0] vals [13] = '{9'd0, 9'd90, 9'd180, 9'd270, 9'd30, 9'd150, 9'd210,
                                  9'd330, 9'd45, 9'd359, 9'd422, 9'd482, 9'd511};
        int         exps [13] = '{0, 65536, 0, -65536, 32768, 32768, -32768,
                                  -32768, 46341, -1144, -65536, -32768, -1144};
        logic signed [31:0] amp;
        int lat;
        for (int i = 0; i < 13; i++) begin
            run_conv(vals[i], amp, lat);
            tests_run++;
            if (amp !== exps[i]) begin
                fails++;
                $display("[TB] FAIL directed_amp value=%0d got=%0d want=%0d", vals[i], amp, exps[i]);
            end
            tests_run++;
            if (lat != 4) begin
                fails++;
                $display("[TB] FAIL directed_latency value=%0d got=%0d want=4", vals[i], lat);
            end
        end
        repeat (3) @(negedge clk_in);
        tests_run++;
        if (amp_out !== exps[12]) begin
            fails++;
            $display("[TB] FAIL amp_hold got=%0d want=%0d", amp_out, exps[12]);
        end
    endtask

    task automatic test_random();
        logic signed [31:0] amp;
        logic [8:0] v;
        int lat;
        int expv;
        for (int i = 0; i < 60; i++) begin
            v    = 9'($urandom);
            expv = ref_sin(v);
            run_conv(v, amp, lat);
            tests_run++;
            if (amp !== expv || lat != 4) begin
                fails++;
                $display("[TB] FAIL random value=%0d got=%0d lat=%0d want=%0d lat=4", v, amp, lat, expv);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk_in);
        end
    endtask

    task automatic test_continuous();
        int pulses;
        int consec;
        int first_at;
        int second_at;
        logic signed [31:0] first_amp;
        logic signed [31:0] second_amp;
        logic prev;
        pulses = 0;
        consec = 0;
        first_at = -1;
        second_at = -1;
        first_amp = 32'sd0;
        second_amp = 32'sd0;
        prev = 1'b0;
        value = 9'd0;
        start = 1'b1;
        @(posedge clk_in);
        #1;
        value = 9'd90;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_in);
            if (done === 1'b1) begin
                if (prev) consec++;
                if (pulses == 0) begin first_at = c; first_amp = amp_out; end
                if (pulses == 1) begin second_at = c; second_amp = amp_out; end
                pulses++;
            end
            prev = done;
        end
        start = 1'b0;
        repeat (6) @(negedge clk_in);
        tests_run++;
        if (first_at != 4 || first_amp !== 32'sd0) begin
            fails++;
            $display("[TB] FAIL cont_first got=%0d at %0d want=0 at 4", first_amp, first_at);
        end
        tests_run++;
        if (second_at != 8 || second_amp !== 32'sd65536) begin
            fails++;
            $display("[TB] FAIL cont_second got=%0d at %0d want=65536 at 8", second_amp, second_at);
        end
        tests_run++;
        if (consec != 0) begin
            fails++;
            $display("[TB] FAIL cont_done_width got=%0d consecutive want=0", consec);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] vq [$];
        int expv;
        for (int i = 0; i < 9; i++) vq.push_back(9'($urandom));
        value = vq[0];
        start = 1'b1;
        for (int e = 0; e < 32; e++) begin
            @(posedge clk_in);
            #1;
            if (e % 4 == 0) value = vq[e / 4 + 1];
            @(negedge clk_in);
            tests_run++;
            if (done !== (e % 4 == 3)) begin
                fails++;
                $display("[TB] FAIL b2b_done edge=%0d got=%b want=%b", e, done, (e % 4 == 3));
            end
            if (e % 4 == 3) begin
                expv = ref_sin(vq[e / 4]);
                tests_run++;
                if (amp_out !== expv) begin
                    fails++;
                    $display("[TB] FAIL b2b_amp value=%0d got=%0d want=%0d", vq[e / 4], amp_out, expv);
                end
            end
        end
        start = 1'b0;
        repeat (6) @(negedge clk_in);
    endtask

    task automatic test_reset_mid();
        logic signed [31:0] amp;
        int lat;
        int seen;
        run_conv(9'd90, amp, lat);
        tests_run++;
        if (amp !== 32'sd65536) begin
            fails++;
            $display("[TB] FAIL pre_abort got=%0d want=65536", amp);
        end
        value = 9'd270;
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        seen = 0;
        @(negedge clk_in);
        if (done !== 1'b0) seen++;
        tests_run++;
        if (amp_out !== 32'sd0) begin
            fails++;
            $display("[TB] FAIL abort_amp got=%0d want=0", amp_out);
        end
        rst_in = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            if (done !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("[TB] FAIL abort_done got=%0d pulses want=0", seen);
        end
        run_conv(9'd60, amp, lat);
        tests_run++;
        if (amp !== 32'sd56756 || lat != 4) begin
            fails++;
            $display("[TB] FAIL after_abort got=%0d lat=%0d want=56756 lat=4", amp, lat);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        start  = 1'b0;
        value  = 9'd0;
        test_reset();
        test_directed();
        test_random();
        test_continuous();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/sine.md
# sine

Sequential sine evaluator: converts a 9-bit integer angle in degrees to a signed Q16.16 sine amplitude using a quarter-wave lookup table and quadrant folding. It serves the view-vector generator, which builds forward/up/right orientation vectors from pitch/roll/yaw. That generator holds `start` high and consumes each result on `done`.

## Interface
- No parameters. Output format is fixed at Q16.16: 16 fractional bits, 1.0 = 65536.
- `clk_in` in, 1: single clock. All logic is on the rising edge.
- `rst_in` in, 1: synchronous, active-high reset.
- `start` in, 1: request a conversion. Sampled only while IDLE.
- `value` in, 9: angle in degrees. 0–359 is taken literally. 360–511 means value−512 degrees (−152…−1), so callers may pass wrapped `90 − x`.
- `done` out, 1: one-cycle pulse; `amp_out` is valid and newly updated this cycle.
- `amp_out` out, 32 signed: sin(value) in Q16.16, range −65536…+65536. Holds its value between conversions.

## Operation
- States: IDLE → REDUCE → LOOKUP → OUTPUT → IDLE.
- IDLE:
  - If `start`=1, capture `value` into an internal register and go to REDUCE.
  - Otherwise stay in IDLE.
- REDUCE:
  - Form signed angle a: a = value if value < 360, else value − 512.
  - If a < 0, add 360, giving a in 0…359.
  - Fold to index k in 0…90 and sign s:
    - a 0…90: k = a, s = +.
    - a 91…180: k = 180 − a, s = +.
    - a 181…270: k = a − 180, s = −.
    - a 271…359: k = 360 − a, s = −.
- LOOKUP: register T[k] from the quarter-wave ROM.
  - T[k] = round(65536·sin(k°)), unsigned 17 bits.
  - Key entries: T[0]=0, T[30]=32768, T[45]=46341, T[60]=56756, T[90]=65536.
- OUTPUT:
  - Set `amp_out` ← s ? −T[k] : T[k], sign-extended to 32 bits.
  - Assert `done` for this cycle only, then return to IDLE.
- `value` changes after capture do not affect the conversion in flight. `start` is ignored outside IDLE.
- Zero results are always +0; negative zero is never produced.

## Timing
- Reset values: `done`=0, `amp_out`=0, state IDLE, captured angle 0.
- Latency: `start` sampled high in IDLE at edge N → `done` is high and `amp_out` valid during the cycle after edge N+3.
- `done` never stays high for two consecutive cycles.
- With `start` held high continuously, IDLE re-accepts on the edge ending the `done` cycle. `done` then pulses every 4 cycles, each pulse using `value` as sampled at its IDLE edge.
- Reset asserted mid-conversion aborts it: no `done` pulse, and the outputs return to their reset values on the next edge.
- Reset takes priority over `start` in the same cycle.

## Structure
- Shared package `trig_pkg` holds:
  - `FRAC_BITS`=16 and `FIXED_ONE`=65536.
  - `DEG_360`=360.
  - The state enum `sine_state_t` (IDLE, REDUCE, LOOKUP, OUTPUT).
- Sub-module `sine_quarter_rom`: combinational 91-entry case table (k in 0…90 → 17-bit T[k]). Indices 91–127 return 0.
- The top-level `sine` contains the FSM, angle reduction, sign application and output registers.

## Test plan
- Reset: hold `rst_in` 2 cycles → `done`=0, `amp_out`=0. Release with `start`=0 → `done` stays 0 for 10 cycles.
- Cardinal angles: `value`=0, 90, 180, 270 → `amp_out`=0, 65536, 0, −65536. Each `done` comes exactly 4 cycles after `start` is accepted.
- Interior angles: 30 → 32768; 150 → 32768; 210 → −32768; 330 → −32768; 45 → 46341; 359 → −1144.
- Wrapped negative input: `value`=422 (−90) → −65536; 482 (−30) → −32768; 511 (−1) → −1144.
- Continuous mode: hold `start`=1 and change `value` 0→90 mid-conversion → the first `done` reports 0, the next (4 cycles later) reports 65536. `done` is never high on consecutive cycles.
- Reset mid-operation: assert `rst_in` in LOOKUP → no `done` pulse, `amp_out`=0. The next `start` with 60 → 56756.
